// File: rtl/msrv32_instr_queue.sv
// Instruction queue between fetch and decode: circular buffer of DEPTH words.
// Optional same-cycle fetch-to-decode bypass when empty: define MSRV32_IQ_BYPASS_EN.
module msrv32_instr_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     ms_riscv32_mp_clk_in,
  input  logic                     ms_riscv32_mp_rstn_in,
  input  logic                     flush_in,
  input  logic [31:0]              ms_riscv32_mp_instr_in,
  input  logic                     instr_valid_in,
  output logic                     instr_ready_out,
  input  logic                     dec_ready_in,
  output logic                     dec_valid_out,
  output logic [6:0]               opcode_out,
  output logic [2:0]               funct3_out,
  output logic [6:0]               funct7_out,
  output logic [4:0]               rs1addr_out,
  output logic [4:0]               rs2addr_out,
  output logic [4:0]               rdaddr_out,
  output logic [11:0]              csr_addr_out,
  output logic [31:7]              instr_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     mem_q [DEPTH];

  logic        empty, full;
  logic        push, pop;
  logic        bypass;
  logic [31:0] instr_pres;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // Ready is also held low while reset is asserted.
  assign instr_ready_out = ms_riscv32_mp_rstn_in && !full && !flush_in;

`ifdef MSRV32_IQ_BYPASS_EN
  assign bypass = ms_riscv32_mp_rstn_in && empty && !flush_in && instr_valid_in;
`else
  assign bypass = 1'b0;
`endif

  assign dec_valid_out = (!empty && !flush_in) || bypass;

  // A bypassed word that is consumed is written and read in the same cycle,
  // so both pointers advance and the count stays at zero.
  assign push = instr_valid_in && instr_ready_out;
  assign pop  = dec_valid_out && dec_ready_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rstn_in) begin
    if (!ms_riscv32_mp_rstn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is presented.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) mem_q[wr_ptr_q] <= ms_riscv32_mp_instr_in;
  end

  always_comb begin
    instr_pres = NOP_INSTR;
    if (dec_valid_out) begin
      instr_pres = bypass ? ms_riscv32_mp_instr_in : mem_q[rd_ptr_q];
    end
  end

  assign opcode_out   = instr_pres[6:0];
  assign funct3_out   = instr_pres[14:12];
  assign funct7_out   = instr_pres[31:25];
  assign rs1addr_out  = instr_pres[19:15];
  assign rs2addr_out  = instr_pres[24:20];
  assign rdaddr_out   = instr_pres[11:7];
  assign csr_addr_out = instr_pres[31:20];
  assign instr_out    = instr_pres[31:7];
  assign count_out    = count_q;

endmodule

// File: tb/tb_msrv32_instr_queue.sv
// Self-checking bench for msrv32_instr_queue: queue-based reference model checked
// every negative edge, plus directed literal checks.
module tb_msrv32_instr_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef MSRV32_IQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        dready = 1'b0;
  logic        ready, dvalid;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] csr;
  logic [31:7] iword;
  logic [2:0]  count;

  msrv32_instr_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rstn_in  (rstn),
    .flush_in               (flush),
    .ms_riscv32_mp_instr_in (instr),
    .instr_valid_in         (valid),
    .instr_ready_out        (ready),
    .dec_ready_in           (dready),
    .dec_valid_out          (dvalid),
    .opcode_out             (opcode),
    .funct3_out             (funct3),
    .funct7_out             (funct7),
    .rs1addr_out            (rs1),
    .rs2addr_out            (rs2),
    .rdaddr_out             (rd),
    .csr_addr_out           (csr),
    .instr_out              (iword),
    .count_out              (count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents of the queue in push order.
  logic [31:0] q[$];

  always @(negedge clk) begin : compare_p
    logic [31:0] w;
    bit          ev, er, pu, po;
    int          n;
    n = q.size();
    if (!rstn) begin
      q.delete();
      n  = 0;
      ev = 1'b0;
      er = 1'b0;
    end else begin
      er = (n < DEPTH) && !flush;
      ev = !flush && (n != 0 || (Byp && valid));
    end
    w = !ev ? NOP : (n != 0 ? q[0] : instr);
    chk("m_ready", 32'(ready), 32'(er));
    chk("m_valid", 32'(dvalid), 32'(ev));
    chk("m_count", 32'(count), 32'(n));
    chk("m_fields", {funct7, rs2, rs1, funct3, rd, opcode}, w);
    chk("m_csr", 32'(csr), 32'(w[31:20]));
    chk("m_instr", 32'(iword), 32'(w[31:7]));
    if (rstn) begin
      if (flush) begin
        q.delete();
      end else begin
        po = ev && dready;
        pu = valid && er;
        if (po && n != 0) void'(q.pop_front());
        if (pu && !(po && n == 0)) q.push_back(instr);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] w, input bit d, input bit f);
    valid  = v;
    instr  = w;
    dready = d;
    flush  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233};

  initial begin
    // Reset with a fetch word offered: nothing may be accepted or presented.
    drive(1'b1, 32'h00500093, 1'b1, 1'b0);
    #3;
    chk("rst_opcode", 32'(opcode), 32'h13);
    chk("rst_valid", 32'(dvalid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    tick();
    rstn = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rel_ready", 32'(ready), 32'd1);

    // Fill with decode stalled.
    foreach (fill[i]) begin
      drive(1'b1, fill[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(ready), 32'd0);
    chk("fill_rd", 32'(rd), 32'd1);
    chk("fill_rs1", 32'(rs1), 32'd0);

    // Push+pop while full: only the pop takes effect.
    drive(1'b1, 32'h00C00293, 1'b1, 1'b0);
    #1;
    chk("full_ready", 32'(ready), 32'd0);
    tick();
    chk("full_pp_count", 32'(count), 32'd3);
    chk("full_pp_rd", 32'(rd), 32'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pop_count", 32'(count), 32'd2);
    chk("pop_rd", 32'(rd), 32'd3);
    drive(1'b1, 32'h00C00293, 1'b1, 1'b0);
    tick();
    chk("pp2_count", 32'(count), 32'd2);
    chk("pp2_funct7", 32'(funct7), 32'h20);
    drive(1'b1, 32'h00100313, 1'b0, 1'b0);
    tick();
    chk("push3_count", 32'(count), 32'd3);

    // Flush with three entries queued.
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("flush_opcode", 32'(opcode), 32'h13);
    chk("flush_valid", 32'(dvalid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("flush_count", 32'(count), 32'd0);

    // Ten push/pop pairs of distinct addi words: order checked by the model.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, {12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("wrap_count", 32'(count), 32'd0);

    // Fetch into an empty queue with decode ready.
    drive(1'b1, 32'h00500093, 1'b1, 1'b0);
    #1;
`ifdef MSRV32_IQ_BYPASS_EN
    chk("byp_valid", 32'(dvalid), 32'd1);
    chk("byp_rd", 32'(rd), 32'd1);
    tick();
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_valid0", 32'(dvalid), 32'd0);
    tick();
    chk("nobyp_valid1", 32'(dvalid), 32'd1);
    chk("nobyp_rd", 32'(rd), 32'd1);
    chk("nobyp_count", 32'(count), 32'd1);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drain_count", 32'(count), 32'd0);

    // Reset mid-operation discards queued entries.
    drive(1'b1, 32'h00700393, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00800413, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(dvalid), 32'd0);
    chk("mrst_opcode", 32'(opcode), 32'h13);
    tick();
    rstn = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(dvalid), 32'd0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/msrv32_instr_queue.md
MSRV32_INSTR_QUEUE -- requirements
Module: msrv32_instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries; power of two, 2..16.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, instruction word presented on flush or empty.
REQ-003 SHALL have ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have ms_riscv32_mp_rstn_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have flush_in  input  1  discard all queued instructions.
REQ-006 SHALL have ms_riscv32_mp_instr_in  input  32  fetched instruction word.
REQ-007 SHALL have instr_valid_in  input  1  fetch word valid.
REQ-008 SHALL have instr_ready_out  output  1  queue accepts a word this cycle.
REQ-009 SHALL have dec_ready_in  input  1  decode consumer takes the head entry.
REQ-010 SHALL have dec_valid_out  output  1  head fields are a real instruction.
REQ-011 SHALL have opcode_out 7, funct3_out 3, funct7_out 7, rs1addr_out 5, rs2addr_out 5, rdaddr_out 5, csr_addr_out 12, instr_out [31:7] (all outputs), sliced from the presented word as bits [6:0], [14:12], [31:25], [19:15], [24:20], [11:7], [31:20], [31:7].
REQ-012 SHALL have count_out  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL store words in a circular buffer with write/read pointers wrapping from DEPTH-1 to 0.
REQ-014 SHALL push when instr_valid_in && instr_ready_out; pop when dec_valid_out && dec_ready_in.
REQ-015 SHALL drive instr_ready_out = (count_out != DEPTH) && !flush_in, with no dependence on dec_ready_in.
REQ-016 SHALL keep count unchanged on simultaneous push and pop; increment on push only; decrement on pop only.
REQ-017 SHALL drive dec_valid_out = (count_out != 0) && !flush_in (bypass case per REQ-027).
REQ-018 SHALL present the head entry on the decode fields whenever dec_valid_out=1; otherwise present NOP_INSTR.
REQ-019 SHALL make a word pushed at edge N visible on the outputs from edge N onward when the queue was empty (one-cycle latency).
REQ-020 SHALL, with flush_in=1, ignore push and pop, present NOP_INSTR combinationally that cycle, and set both pointers and count to 0 at the next edge.
REQ-021 SHALL not change state when push is requested while full (instr_ready_out=0) or pop while empty.
REQ-022 SHALL hold head fields stable while dec_valid_out=1 and dec_ready_in=0.

Reset
REQ-023 SHALL on ms_riscv32_mp_rstn_in=0 immediately clear pointers and count; instr_ready_out=0, dec_valid_out=0, count_out=0, decode fields = NOP_INSTR slices (opcode 7'h13, others 0).
REQ-024 SHALL, on reset asserted mid-operation, discard all entries; no queued word reappears after release.
REQ-025 SHALL raise instr_ready_out in the first cycle after reset release.
REQ-026 SHALL not require storage array reset; only pointers and count.

Configuration
REQ-027 SHALL with MSRV32_IQ_BYPASS_EN defined: when count=0, flush_in=0 and instr_valid_in=1, present ms_riscv32_mp_instr_in on the fields with dec_valid_out=1 the same cycle; if dec_ready_in=1 the word is consumed and not stored.
REQ-028 SHALL without MSRV32_IQ_BYPASS_EN: no combinational path from instr_in/instr_valid_in to decode outputs; latency per REQ-019.

Verification
REQ-029 SHALL cover reset: rstn low -> opcode_out=7'h13, dec_valid_out=0, count_out=0, instr_ready_out=0.
REQ-030 SHALL cover fill: DEPTH=4, push 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233 with dec_ready_in=0 -> count_out=4, instr_ready_out=0, head rdaddr_out=1, rs1addr_out=0.
REQ-031 SHALL cover push+pop when full: count 4, valid=1, dec_ready=1 -> no push accepted, count 3 next cycle; push+pop at count 2 -> count stays 2.
REQ-032 SHALL cover flush: count 3, flush_in=1 -> same cycle opcode_out=7'h13, dec_valid_out=0; next cycle count_out=0.
REQ-033 SHALL cover wrap-around: 10 push/pop pairs of distinct words -> outputs in push order, pointers wrap, no loss.
REQ-034 SHALL cover bypass: empty, push 32'h00500093 with dec_ready_in=1 -> with MSRV32_IQ_BYPASS_EN same-cycle dec_valid_out=1, rdaddr_out=1, count stays 0; without it dec_valid_out=1 one cycle later.
